// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into little-endian words, writes instruction memory,
// then releases the core from reset. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader #(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [7:0]           rx_data,
  output logic                 imem_we,
  output logic [ADDR_BITS-1:0] imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = ADDR_BITS + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, LOAD, CHK, DONE, ERR} state_t;
  localparam state_t AFTER_LOAD = CHK;
`else
  typedef enum logic [2:0] {HDR, LOAD, DONE, ERR} state_t;
  localparam state_t AFTER_LOAD = DONE;
`endif

  state_t                 state, state_d;
  logic [1:0]             byte_idx, byte_idx_d;
  logic [CW-1:0]          word_cnt, word_cnt_d;
  logic [7:0]             n_words, n_words_d;
  logic [23:0]            word_buf, word_buf_d;
  logic [7:0]             csum, csum_d;
  logic                   we_d, ready_d, busy_d, done_d, core_rst_n_d, err_d;
  logic [ADDR_BITS-1:0]   addr_d;
  logic [31:0]            wdata_d;
  logic                   fire;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR;
      byte_idx   <= 2'd0;
      word_cnt   <= '0;
      n_words    <= 8'd0;
      word_buf   <= 24'd0;
      csum       <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      rx_ready   <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      core_rst_n <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      byte_idx   <= byte_idx_d;
      word_cnt   <= word_cnt_d;
      n_words    <= n_words_d;
      word_buf   <= word_buf_d;
      csum       <= csum_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      rx_ready   <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
      core_rst_n <= core_rst_n_d;
      err        <= err_d;
    end
  end

  assign fire = rx_valid && rx_ready;

  // Next state and output values
  always_comb begin
    state_d    = state;
    byte_idx_d = byte_idx;
    word_cnt_d = word_cnt;
    n_words_d  = n_words;
    word_buf_d = word_buf;
    csum_d     = csum;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;

    case (state)
      HDR: begin
        if (fire) begin
          n_words_d  = rx_data;
          byte_idx_d = 2'd0;
          word_cnt_d = '0;
          csum_d     = 8'd0;
          if (32'(rx_data) > 32'(DEPTH)) state_d = ERR;
          else if (rx_data == 8'd0)      state_d = AFTER_LOAD;
          else                           state_d = LOAD;
        end
      end
      LOAD: begin
        if (fire) begin
          csum_d     = csum ^ rx_data;
          byte_idx_d = byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    word_buf_d[7:0]   = rx_data;
            2'd1:    word_buf_d[15:8]  = rx_data;
            2'd2:    word_buf_d[23:16] = rx_data;
            default: begin
              wdata_d    = {rx_data, word_buf};
              addr_d     = word_cnt[ADDR_BITS-1:0];
              we_d       = 1'b1;
              word_cnt_d = word_cnt + CW'(1);
              if (32'(word_cnt) + 32'd1 == 32'(n_words)) state_d = AFTER_LOAD;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (fire) state_d = (rx_data == csum) ? DONE : ERR;
      end
`endif
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase

    // done/core release lag the DONE transition by one cycle so the last write lands first
    ready_d      = (state_d != DONE) && (state_d != ERR);
    err_d        = (state_d == ERR);
    busy_d       = (state_d != ERR) && (state != DONE);
    done_d       = (state == DONE);
    core_rst_n_d = (state == DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN to add trailing check bytes.
module tb_imem_loader;

  localparam int unsigned ADDR_BITS = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx_valid = 1'b0;
  logic                 rx_ready;
  logic [7:0]           rx_data = 8'd0;
  logic                 imem_we;
  logic [ADDR_BITS-1:0] imem_addr;
  logic [31:0]          imem_wdata;
  logic                 core_rst_n, busy, done, err;

  imem_loader #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_n = 0;
  int last_we_cyc = 0;
  int done_cyc;
  int base;
  logic [31:0] wr_addr [0:511];
  logic [31:0] wr_data [0:511];
  logic [7:0]  img [0:255];
  logic [7:0]  xsum;
  logic [31:0] exp_word;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we && wr_n < 512) begin
      wr_addr[wr_n] = 32'(imem_addr);
      wr_data[wr_n] = imem_wdata;
      wr_n++;
      last_we_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Offer one byte; returns at posedge+1 after the transfer edge
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    done_cyc = cyc;
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // 1) reset and idle
    do_reset();
    base = wr_n;
    repeat (10) @(posedge clk);
    #1;
    check("idle_core_rst_n", 32'(core_rst_n), 32'd0);
    check("idle_busy",       32'(busy),       32'd1);
    check("idle_rx_ready",   32'(rx_ready),   32'd1);
    check("idle_done_err",   32'({done, err}), 32'd0);
    check("idle_no_write",   32'(wr_n - base), 32'd0);

    // 2) two-word program
    do_reset();
    base = wr_n;
    send(8'h02);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    check("t2_not_released", 32'(core_rst_n), 32'd0);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h90);
`endif
    wait_done();
    check("t2_nwrites", 32'(wr_n - base), 32'd2);
    check("t2_addr0", wr_addr[base],   32'd0);
    check("t2_data0", wr_data[base],   32'h0000_0013);
    check("t2_addr1", wr_addr[base+1], 32'd1);
    check("t2_data1", wr_data[base+1], 32'h0010_0093);
    check("t2_core_rst_n", 32'(core_rst_n), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_release_after_write", 32'(done_cyc > last_we_cyc), 32'd1);
`else
    check("t2_release_cycle", 32'(done_cyc), 32'(last_we_cyc + 1));
`endif
    // DONE ignores further traffic
    rx_data = 8'hFF; rx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1; rx_valid = 1'b0;
    check("t2_done_ready", 32'(rx_ready), 32'd0);
    check("t2_done_no_write", 32'(wr_n - base), 32'd2);

    // 3) oversize header
    do_reset();
    base = wr_n;
    send(8'h41);
    check("t3_err", 32'(err), 32'd1);
    check("t3_ready", 32'(rx_ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_core_rst_n", 32'(core_rst_n), 32'd0);
    check("t3_no_write", 32'(wr_n - base), 32'd0);

    // 4) full memory with random gaps
    do_reset();
    base = wr_n;
    xsum = 8'd0;
    for (int i = 0; i < 256; i++) begin
      img[i] = 8'(i * 7 + 3);
      xsum = xsum ^ img[i];
    end
    send(8'h40);
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(img[i]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(xsum);
`endif
    wait_done();
    check("t4_nwrites", 32'(wr_n - base), 32'd64);
    for (int k = 0; k < 64; k++) begin
      exp_word = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
      check("t4_addr", wr_addr[base+k], 32'(k));
      check("t4_data", wr_data[base+k], exp_word);
    end
    check("t4_done", 32'(done), 32'd1);

    // 5) reset mid-load, then restart
    do_reset();
    send(8'h01); send(8'hAA); send(8'hBB);
    do_reset();
    check("t5_reset_busy", 32'(busy), 32'd1);
    base = wr_n;
    send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    wait_done();
    check("t5_nwrites", 32'(wr_n - base), 32'd1);
    check("t5_addr", wr_addr[base], 32'd0);
    check("t5_data", wr_data[base], 32'hDDCC_BBAA);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6) checksum mismatch, then match
    do_reset();
    base = wr_n;
    send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    check("t6_err", 32'(err), 32'd1);
    check("t6_written", 32'(wr_n - base), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_core_rst_n", 32'(core_rst_n), 32'd0);
    do_reset();
    send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
    wait_done();
    check("t6_done", 32'(done), 32'd1);
    check("t6_err_clear", 32'(err), 32'd0);
    // empty image needs checksum 0x00
    do_reset();
    send(8'h00); send(8'h00);
    wait_done();
    check("t6_empty_done", 32'(done), 32'd1);
`else
    // 6) empty image goes straight to DONE
    do_reset();
    base = wr_n;
    send(8'h00);
    wait_done();
    check("t6_empty_done", 32'(done), 32'd1);
    check("t6_empty_no_write", 32'(wr_n - base), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
